// File: rtl/time_counter.sv
// BCD timekeeping core: hh:mm:ss in 24 h and 12 h form, plus display digit-scan select.
// Latency: digits update one clock after a qualifying pulse; 12 h digits and pm follow hr0/hr1 combinationally.
// Backpressure: none; each en_1hz/inc_min/inc_hr pulse is consumed in the cycle it arrives.
module time_counter #(
  parameter int SCAN_W = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_1hz,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic [3:0] hr0,
  output logic [3:0] hr1,
  output logic [3:0] hr0_12hr,
  output logic [3:0] hr1_12hr,
  output logic       pm,
  output logic       day_tick,
  output logic [1:0] scan_sel
);

  logic              tick;
  logic              sec0_max;
  logic              sec1_max;
  logic              min0_max;
  logic              min1_max;
  logic              hr_max;
  logic              sec_wrap;
  logic              min_wrap;
  logic              min_step;
  logic              hr_step;
  logic              day_wrap;
  logic [SCAN_W-1:0] scan_cnt;

  // Seconds only count in run mode; set_mode is sampled alongside en_1hz,
  // so a tick arriving as set_mode rises is dropped.
  assign tick = en_1hz & ~set_mode;

  // Wrap compares use >= so a glitched non-BCD digit falls back into range.
  assign sec0_max = (sec0 >= 4'd9);
  assign sec1_max = (sec1 >= 4'd5);
  assign min0_max = (min0 >= 4'd9);
  assign min1_max = (min1 >= 4'd5);
  assign hr_max   = ((hr1 >= 4'd2) && (hr0 >= 4'd3)) || (hr1 >= 4'd3);

  assign sec_wrap = tick & sec0_max & sec1_max;
  assign min_wrap = min0_max & min1_max;

  // In set mode the increment buttons drive minutes/hours directly and no
  // carry propagates between fields; in run mode only carries advance them.
  assign min_step = set_mode ? inc_min : sec_wrap;
  assign hr_step  = set_mode ? inc_hr  : (sec_wrap & min_wrap);
  assign day_wrap = ~set_mode & sec_wrap & min_wrap & hr_max;

  // Seconds digits: units 0..9, tens 0..5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec0 <= 4'd0;
      sec1 <= 4'd0;
    end else if (tick) begin
      if (sec0_max) begin
        sec0 <= 4'd0;
        sec1 <= sec1_max ? 4'd0 : sec1 + 4'd1;
      end else begin
        sec0 <= sec0 + 4'd1;
      end
    end
  end

  // Minutes digits: same structure as seconds, advanced by carry or inc_min.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min0 <= 4'd0;
      min1 <= 4'd0;
    end else if (min_step) begin
      if (min0_max) begin
        min0 <= 4'd0;
        min1 <= min1_max ? 4'd0 : min1 + 4'd1;
      end else begin
        min0 <= min0 + 4'd1;
      end
    end
  end

  // Hours digits: 00..23 BCD, 23 wraps to 00, x9 carries into the tens digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr0 <= 4'd0;
      hr1 <= 4'd0;
    end else if (hr_step) begin
      if (hr_max) begin
        hr0 <= 4'd0;
        hr1 <= 4'd0;
      end else if (hr0 >= 4'd9) begin
        hr0 <= 4'd0;
        hr1 <= hr1 + 4'd1;
      end else begin
        hr0 <= hr0 + 4'd1;
      end
    end
  end

  // Day pulse registered so it is high in the same cycle the display shows 00:00:00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_tick <= 1'b0;
    end else begin
      day_tick <= day_wrap;
    end
  end

  // Free-running scan divider; keeps running in set mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign scan_sel = scan_cnt[SCAN_W-1 -: 2];

  // 24 h -> 12 h via BCD subtract-12: 00 shows 12, 13..23 drop by 12 with a
  // borrow from the tens digit when the units digit is below 2.
  always_comb begin
    hr0_12hr = hr0;
    hr1_12hr = hr1;
    pm       = (hr1 >= 4'd2) || ((hr1 == 4'd1) && (hr0 >= 4'd2));
    if ((hr1 == 4'd0) && (hr0 == 4'd0)) begin
      hr1_12hr = 4'd1;
      hr0_12hr = 4'd2;
    end else if ((hr1 >= 4'd2) || ((hr1 == 4'd1) && (hr0 >= 4'd3))) begin
      if (hr0 >= 4'd2) begin
        hr0_12hr = hr0 - 4'd2;
        hr1_12hr = hr1 - 4'd1;
      end else begin
        hr0_12hr = hr0 + 4'd8;
        hr1_12hr = hr1 - 4'd2;
      end
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with a 4-bit scan divider.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: none; stimulus pulses are one cycle wide.
module tb_time_counter;

  logic       clk;
  logic       rst_n;
  logic       en_1hz;
  logic       set_mode;
  logic       inc_min;
  logic       inc_hr;
  logic [3:0] sec0, sec1, min0, min1, hr0, hr1, hr0_12hr, hr1_12hr;
  logic       pm;
  logic       day_tick;
  logic [1:0] scan_sel;

  int checks = 0;
  int errors = 0;

  time_counter #(.SCAN_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_1hz   (en_1hz),
    .set_mode (set_mode),
    .inc_min  (inc_min),
    .inc_hr   (inc_hr),
    .sec0     (sec0),
    .sec1     (sec1),
    .min0     (min0),
    .min1     (min1),
    .hr0      (hr0),
    .hr1      (hr1),
    .hr0_12hr (hr0_12hr),
    .hr1_12hr (hr1_12hr),
    .pm       (pm),
    .day_tick (day_tick),
    .scan_sel (scan_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] now_24();
    return {8'h0, hr1, hr0, min1, min0, sec1, sec0};
  endfunction

  function automatic logic [31:0] now_12();
    return {19'h0, pm, hr1_12hr, hr0_12hr};
  endfunction

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic step(input logic e, input logic s, input logic im, input logic ih);
    en_1hz   = e;
    set_mode = s;
    inc_min  = im;
    inc_hr   = ih;
    @(posedge clk);
    #1;
    en_1hz  = 1'b0;
    inc_min = 1'b0;
    inc_hr  = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    en_1hz   = 1'b0;
    set_mode = 1'b0;
    inc_min  = 1'b0;
    inc_hr   = 1'b0;

    // Reset held for 3 cycles with a tick pending: reset must win.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    check_val("reset_24h", now_24(), 32'h000000);
    check_val("reset_12h", now_12(), 32'h012);
    check_val("reset_scan", {30'h0, scan_sel}, 32'h0);
    check_val("reset_day_tick", {31'h0, day_tick}, 32'h0);

    // Seconds and minutes carry.
    run_ticks(58);
    check_val("sec_58", now_24(), 32'h000058);
    run_ticks(1);
    check_val("sec_59", now_24(), 32'h000059);
    run_ticks(1);
    check_val("min_carry", now_24(), 32'h000100);
    run_ticks(539);
    check_val("at_00_09_59", now_24(), 32'h000959);
    run_ticks(1);
    check_val("min_tens_carry", now_24(), 32'h001000);

    // 12 h mapping, hours set via inc_hr (time now 00:10:00).
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("h11_24h", now_24(), 32'h111000);
    check_val("h11_12h", now_12(), 32'h011);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("h12_12h", now_12(), 32'h112);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("h13_12h", now_12(), 32'h101);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("h23_24h", now_24(), 32'h231000);
    check_val("h23_12h", now_12(), 32'h111);

    // Day rollover: set minutes to 59, then run seconds up to 59.
    for (int i = 0; i < 49; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("set_23_59", now_24(), 32'h235900);
    run_ticks(59);
    check_val("at_23_59_59", now_24(), 32'h235959);
    check_val("no_early_day_tick", {31'h0, day_tick}, 32'h0);
    run_ticks(1);
    check_val("rollover_24h", now_24(), 32'h000000);
    check_val("rollover_day_tick", {31'h0, day_tick}, 32'h1);
    check_val("rollover_12h", now_12(), 32'h012);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("day_tick_one_cycle", {31'h0, day_tick}, 32'h0);

    // Set mode: build 10:59:30, then adjust.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    run_ticks(30);
    check_val("at_10_59_30", now_24(), 32'h105930);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("set_min_wrap_no_carry", now_24(), 32'h100030);
    check_val("set_no_day_tick", {31'h0, day_tick}, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_val("set_min_and_hr", now_24(), 32'h110130);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("set_ticks_ignored", now_24(), 32'h110130);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("tick_on_set_rise", now_24(), 32'h110130);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("run_resumes", now_24(), 32'h110131);

    // Asynchronous reset mid-cycle clears everything before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_24h", now_24(), 32'h000000);
    check_val("async_reset_scan", {30'h0, scan_sel}, 32'h0);
    rst_n = 1'b1;

    // Scan sequence: 4 cycles per value, set_mode toggled partway.
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, (k >= 6 && k < 11), 1'b0, 1'b0);
      if (k == 3 || k == 4 || k == 8 || k == 12 || k == 16)
        check_val($sformatf("scan_k%0d", k), {30'h0, scan_sel}, 32'((k / 4) % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
